// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// halt FSM states and the scoreboard entry layout.
package hazard_ctrl_pkg;

   // Forwarding select per read port
   localparam logic [1:0] NO_FWD       = 2'd0;
   localparam logic [1:0] FWD_FROM_EX  = 2'd1;
   localparam logic [1:0] FWD_FROM_MEM = 2'd2;
   localparam logic [1:0] FWD_FROM_WB  = 2'd3;

   // Scoreboard register field is sized for the widest supported core;
   // narrower register addresses are zero-extended into it.
   localparam int SB_REG_W = 8;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic                valid;
      logic                wr_en;
      logic [SB_REG_W-1:0] wr_reg;
      logic                is_load;
      logic                is_hlt;
   } sb_entry_t;

   // Entry holds a real instruction that will write the register file
   function automatic logic sb_writes(input sb_entry_t e);
      return e.valid & e.wr_en;
   endfunction

endpackage

// File: rtl/hazard_ctrl_port_cmp.sv
// One ID read port checked against the EX/MEM/WB scoreboard entries;
// reports raw hits and the youngest-producer forwarding select.
module hzd_port_cmp
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 4,
   parameter int ZERO_REG_HW = 1
) (
   input  logic                  rd_en,
   input  logic [REG_ADDR_W-1:0] rd_reg,
   input  sb_entry_t             ex,
   input  sb_entry_t             mem,
   input  sb_entry_t             wb,
   output logic                  hit_ex,
   output logic                  hit_mem,
   output logic [1:0]            sel
);

   logic [SB_REG_W-1:0] reg_x;
   logic                chk;
   logic                hit_wb;

   assign reg_x   = SB_REG_W'(rd_reg);
   // Register 0 is hardwired, so reading it never depends on a producer
   assign chk     = rd_en & ((ZERO_REG_HW == 0) || (rd_reg != '0));
   assign hit_ex  = chk & sb_writes(ex)  & (ex.wr_reg  == reg_x);
   assign hit_mem = chk & sb_writes(mem) & (mem.wr_reg == reg_x);
   assign hit_wb  = chk & sb_writes(wb)  & (wb.wr_reg  == reg_x);

   // Youngest producer wins: EX over MEM over WB
   always_comb begin
      sel = NO_FWD;
      if (hit_ex)       sel = FWD_FROM_EX;
      else if (hit_mem) sel = FWD_FROM_MEM;
      else if (hit_wb)  sel = FWD_FROM_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: in-flight destination scoreboard, forwarding
// selects, load-use / interlock stalls, branch squash and halt drain.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int NUM_RD_PORTS = 2,
   parameter int REG_ADDR_W   = 4,
   parameter int FWD_EN       = 1,
   parameter int ZERO_REG_HW  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             id_valid,
   input  logic [NUM_RD_PORTS-1:0]          id_rd_en,
   input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_rd_reg,
   input  logic                             id_wr_en,
   input  logic [REG_ADDR_W-1:0]            id_wr_reg,
   input  logic                             id_is_load,
   input  logic                             id_is_hlt,
   input  logic                             br_taken,
   output logic [2*NUM_RD_PORTS-1:0]        fwd_sel,
   output logic                             stall_if,
   output logic                             bubble_ex,
   output logic                             flush_if_id,
   output logic                             flush_id_ex,
   output logic                             en_ex_mem,
   output logic                             en_mem_wb,
   output logic                             halted
);

   sb_entry_t sb_ex, sb_mem, sb_wb, id_ent;
   hz_state_e state, state_nxt;

   logic [NUM_RD_PORTS-1:0]      hit_ex, hit_mem;
   logic [NUM_RD_PORTS-1:0][1:0] port_sel;
   logic                         load_use, raw_stall, br_eff, accept;

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      hzd_port_cmp #(
         .REG_ADDR_W  (REG_ADDR_W),
         .ZERO_REG_HW (ZERO_REG_HW)
      ) u_cmp (
         .rd_en   (id_rd_en[p]),
         .rd_reg  (id_rd_reg[p*REG_ADDR_W +: REG_ADDR_W]),
         .ex      (sb_ex),
         .mem     (sb_mem),
         .wb      (sb_wb),
         .hit_ex  (hit_ex[p]),
         .hit_mem (hit_mem[p]),
         .sel     (port_sel[p])
      );
   end

   assign load_use  = (|hit_ex) & sb_ex.is_load;
   // With forwarding only a load in EX is unresolvable; without it any
   // producer ahead of WB blocks (WB is covered by regfile write-through).
   assign raw_stall = (FWD_EN != 0) ? load_use : ((|hit_ex) | (|hit_mem));
   // Redirects are meaningless once halted; gated by rst so outputs read
   // as idle while reset is held.
   assign br_eff    = br_taken & ~rst & (state != ST_HALTED);
   assign accept    = id_valid & ~raw_stall & ~br_eff & (state == ST_RUN);

   assign id_ent = '{valid:   1'b1,
                     wr_en:   id_wr_en,
                     wr_reg:  SB_REG_W'(id_wr_reg),
                     is_load: id_is_load,
                     is_hlt:  id_is_hlt};

   // Scoreboard advance; a taken branch squashes the wrong-path EX entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_ex  <= '0;
         sb_mem <= '0;
         sb_wb  <= '0;
      end else if (state != ST_HALTED) begin
         sb_wb  <= sb_mem;
         sb_mem <= br_eff ? '0 : sb_ex;
         sb_ex  <= accept ? id_ent : '0;
      end
   end

   // Halt FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // Next state and all control outputs
   always_comb begin
      state_nxt   = state;
      fwd_sel     = '0;
      stall_if    = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      en_ex_mem   = 1'b1;
      en_mem_wb   = 1'b1;
      halted      = 1'b0;
      case (state)
         ST_RUN: begin
            if (FWD_EN != 0) fwd_sel = port_sel;
            if (br_eff) begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end else begin
               stall_if  = raw_stall;
               bubble_ex = raw_stall;
            end
            // HLT in MEM is past the last redirect point
            if (sb_mem.valid & sb_mem.is_hlt) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (FWD_EN != 0) fwd_sel = port_sel;
            stall_if    = 1'b1;
            bubble_ex   = 1'b1;
            flush_if_id = br_eff;
            flush_id_ex = br_eff;
            if (sb_wb.valid & sb_wb.is_hlt) state_nxt = ST_HALTED;
         end
         ST_HALTED: begin
            halted    = 1'b1;
            stall_if  = 1'b1;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

endmodule
